// File: rtl/ula_pkg.sv
// Shared types and a reference function for the ALU shift datapath.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_t;

  localparam int SHR_REF_W = 16;

  // Golden right shift at the default datapath width.
  function automatic logic [SHR_REF_W-1:0] shr_ref(
    input logic [SHR_REF_W-1:0]         data,
    input logic [$clog2(SHR_REF_W)-1:0] amt,
    input logic                         arith
  );
    logic signed [SHR_REF_W-1:0] s;
    s = data;
    if (arith) s = s >>> amt;
    else       s = data >> amt;
    return s;
  endfunction

endpackage

// File: rtl/mux2.sv
// Two-input word multiplexer.
module mux2 #(
  parameter int W = 1
) (
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? data1 : data0;

endmodule

// File: rtl/srl_seq.sv
// Multi-cycle SRL/SRA: one shift-amount bit resolved per cycle through a single mux stage.
// Define SHIFT_ARITH_EN to honour the arith input; otherwise every operation is a logical shift.
module srl_seq
  import ula_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         data_in,
  input  logic [$clog2(N)-1:0] shift_amount,
  input  logic                 arith,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         data_out
);

  localparam int K  = $clog2(N);
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  shr_state_t     state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [K-1:0]   amt_q, amt_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [N-1:0]   shifted, mux_out;
  logic [K:0]     shamt;
  logic [2*N-1:0] ext;
  logic           fill;

`ifdef SHIFT_ARITH_EN
  logic fill_q, fill_d;
  assign fill = fill_q;
`else
  logic unused_arith;
  assign fill         = 1'b0;
  assign unused_arith = arith;
`endif

  // Stage s shifts by 2**s: pick an N-wide window out of {fill bits, data}.
  assign shamt   = (K+1)'(1) << stage_q;
  assign ext     = {{N{fill}}, data_q};
  assign shifted = ext[shamt +: N];

  mux2 #(.W(N)) u_mux (
    .data0 (data_q),
    .data1 (shifted),
    .sel   (amt_q[stage_q]),
    .y     (mux_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    stage_d = stage_q;
`ifdef SHIFT_ARITH_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          amt_d   = shift_amount;
          stage_d = '0;
`ifdef SHIFT_ARITH_EN
          fill_d  = arith & data_in[N-1];
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d = mux_out;
        if (stage_q == SW'(K-1)) begin
          stage_d = '0;
          state_d = DONE;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

`ifdef SHIFT_ARITH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= 1'b0;
    else        fill_q <= fill_d;
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_srl_seq.sv
// Scoreboard bench for srl_seq: directed cases, hold/abort scenarios and random back-to-back traffic.
module tb_srl_seq;
  import ula_pkg::*;

  localparam int N = 16;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] data_in = '0;
  logic [K-1:0] shift_amount = '0;
  logic         arith = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [N-1:0] exp_q[$];
  int           acc_q[$];

  srl_seq #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .arith        (arith),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur (t=%0t)", name, $time);
  endtask

  // Reference: bit i of the result is source bit i+amt, or the fill bit past the top.
  function automatic logic [N-1:0] model(input logic [N-1:0] d, input int a, input logic ar);
    logic         f;
    logic [N-1:0] r;
`ifdef SHIFT_ARITH_EN
    f = ar & d[N-1];
`else
    f = 1'b0;
`endif
    for (int i = 0; i < N; i++) r[i] = (i + a < N) ? d[i + a] : f;
    return r;
  endfunction

  // driver tasks: called and returning at posedge+#1
  task automatic send(input logic [N-1:0] d, input logic [K-1:0] a, input logic ar,
                      input bit keep, output int acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    data_in = d; shift_amount = a; arith = ar; in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout");
    else begin
      acc = cyc + 1;
      exp_q.push_back(model(d, int'(a), ar));
      acc_q.push_back(acc);
    end
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  // scoreboard monitor
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [N-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail_now("unexpected_out_valid");
        else check("latency", N'(cyc - acc_q.pop_front()), N'(K));
      end
      if (out_valid && prev_valid && !prev_ready) check("hold_stable", data_out, prev_data);
      if (out_valid) check("in_ready_low_in_done", N'(in_ready), '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", data_out, exp_q.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = data_out;
    end
  end

  initial begin
    int  acc, last;
    bit  bad, seen;
    logic [N-1:0] d;
    logic [K-1:0] a;
    logic ar;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", N'(in_ready), N'(1));
    check("reset_out_valid", N'(out_valid), '0);
    check("reset_data_out", data_out, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(16'hF0F0, 4'd4, 1'b0, 1'b0, acc);
    wait_idle();
    send(16'h8000, 4'd15, 1'b1, 1'b0, acc);
    wait_idle();
    send(16'h8000, 4'd15, 1'b0, 1'b0, acc);
    wait_idle();

    send(16'h1234, 4'd0, 1'b0, 1'b0, acc);
    bad = 1'b0;
    for (int t = 0; t < K + 1; t++) begin
      @(negedge clk);
      if (in_ready) bad = 1'b1;
    end
    check("in_ready_low_while_busy", N'(bad), '0);
    wait_idle();

    // Result held in DONE while a second operand is offered.
    out_ready = 1'b0;
    send(16'h5A5A, 4'd3, 1'b1, 1'b0, acc);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("done_timeout");
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; data_in = 16'hFFFF; shift_amount = '0; arith = 1'b0;
      @(negedge clk);
      check("in_ready_held", N'(in_ready), '0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_no_comb_path", N'(in_ready), '0);
    @(negedge clk);
    check("in_ready_after_release", N'(in_ready), N'(1));
    check("out_valid_after_release", N'(out_valid), '0);
    seen = 1'b0;
    for (int t = 0; t < K + 2; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_second_accept", N'(seen), '0);
    @(posedge clk); #1;

    // Asynchronous abort during SHIFT stage 2.
    send(16'hABCD, 4'd5, 1'b0, 1'b0, acc);
    @(posedge clk); @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", N'(out_valid), '0);
    check("abort_data_out", data_out, '0);
    check("abort_in_ready", N'(in_ready), N'(1));
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h00F0, 4'd4, 1'b0, 1'b0, acc);
    wait_idle();

    // Random back-to-back traffic, consumer always ready.
    last = 0;
    for (int i = 0; i < 20; i++) begin
      d  = N'($urandom);
      a  = K'($urandom_range(0, N - 1));
      ar = 1'($urandom_range(0, 1));
      send(d, a, ar, (i < 19), acc);
      if (i > 0) check("issue_interval", N'(acc - last), N'(K + 2));
      last = acc;
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
